fm_out_seq: RTL and testbench

- Transmitter side of the FM channel-output bus consumed by the audio conditioning path.
- Takes one frame of six per-channel stereo samples through a valid/ready handshake.
- Serialises them one slot at a time as MOL/MOR (offset-binary) and MOL_2612/MOR_2612 (signed), with the fm_clk1 slot strobe and the fm_sel23 last-slot marker.
- Used to drive the FM output bus from a parallel FM core or a test source; this is the bus whose receiver accumulates on the fm_clk1 falling edge and flushes on fm_sel23.

---
 rtl/fm_out_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_fm_out_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_out_seq.sv
// FM channel-output bus transmitter: takes six stereo samples per frame over
// valid/ready and plays them out one slot at a time with fm_clk1 / fm_sel23.
module fm_out_seq #(
   parameter int unsigned HALF_DIV = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [53:0] ch_l,
   input  logic [53:0] ch_r,
   output logic        fm_clk1,
   output logic        fm_sel23,
   output logic [8:0]  MOL,
   output logic [8:0]  MOR,
   output logic [9:0]  MOL_2612,
   output logic [9:0]  MOR_2612,
   output logic [2:0]  slot,
   output logic        frame_done,
   output logic        underrun
);

   localparam int unsigned SAMP_W = 9;
   localparam int unsigned BUS_W  = 6 * SAMP_W;
   localparam int unsigned CNT_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [2:0]  LAST_SLOT = 3'd5;

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BUS_W-1:0]   shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
   logic               shadow_full_q, shadow_full_d;
   logic [BUS_W-1:0]   active_l_q, active_l_d, active_r_q, active_r_d;
   logic               fm_clk1_q, fm_clk1_d;
   logic               fm_sel23_q, fm_sel23_d;
   logic [2:0]         slot_q, slot_d;
   logic [SAMP_W-1:0]  mol_q, mol_d, mor_q, mor_d;
   logic [SAMP_W:0]    mol2612_q, mol2612_d, mor2612_q, mor2612_d;
   logic               frame_done_q, frame_done_d;
   logic               underrun_q, underrun_d;

   logic               accept;
   logic               bypass;
   logic               present;
   logic               cnt_last;
   logic [BUS_W-1:0]   src_l, src_r;
   logic [SAMP_W-1:0]  s_l, s_r;

   // Select one channel's 9-bit sample from a packed six-channel bus
   function automatic logic [SAMP_W-1:0] pick(input logic [BUS_W-1:0] bus,
                                              input logic [2:0] idx);
      logic [SAMP_W-1:0] r;
      case (idx)
         3'd0:    r = bus[8:0];
         3'd1:    r = bus[17:9];
         3'd2:    r = bus[26:18];
         3'd3:    r = bus[35:27];
         3'd4:    r = bus[44:36];
         3'd5:    r = bus[53:45];
         default: r = bus[8:0];
      endcase
      return r;
   endfunction

   // Next-state: slot sequencing, frame hand-over and input handshake
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shadow_l_d    = shadow_l_q;
      shadow_r_d    = shadow_r_q;
      shadow_full_d = shadow_full_q;
      active_l_d    = active_l_q;
      active_r_d    = active_r_q;
      fm_clk1_d     = fm_clk1_q;
      fm_sel23_d    = fm_sel23_q;
      slot_d        = slot_q;
      mol_d         = mol_q;
      mor_d         = mor_q;
      mol2612_d     = mol2612_q;
      mor2612_d     = mor2612_q;
      frame_done_d  = 1'b0;
      underrun_d    = 1'b0;
      bypass        = 1'b0;
      present       = 1'b0;
      src_l         = active_l_q;
      src_r         = active_r_q;
      s_l           = '0;
      s_r           = '0;

      accept   = in_valid & ~shadow_full_q;
      cnt_last = (cnt_q == CNT_W'(HALF_DIV - 1));

      if (ce) begin
         case (state_q)
            ST_IDLE: begin
               if (shadow_full_q) begin
                  active_l_d    = shadow_l_q;
                  active_r_d    = shadow_r_q;
                  shadow_full_d = 1'b0;
                  src_l         = shadow_l_q;
                  src_r         = shadow_r_q;
                  slot_d        = 3'd0;
                  fm_sel23_d    = 1'b0;
                  fm_clk1_d     = 1'b1;
                  present       = 1'b1;
                  cnt_d         = '0;
                  state_d       = ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (cnt_last) begin
                  fm_clk1_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_LOW;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_LOW: begin
               if (cnt_last) begin
                  cnt_d     = '0;
                  fm_clk1_d = 1'b1;
                  present   = 1'b1;
                  state_d   = ST_HIGH;
                  if (slot_q != LAST_SLOT) begin
                     slot_d     = slot_q + 3'd1;
                     fm_sel23_d = (slot_q + 3'd1 == LAST_SLOT);
                  end else begin
                     frame_done_d = 1'b1;
                     fm_sel23_d   = 1'b0;
                     slot_d       = 3'd0;
                     if (shadow_full_q) begin
                        active_l_d    = shadow_l_q;
                        active_r_d    = shadow_r_q;
                        shadow_full_d = 1'b0;
                        src_l         = shadow_l_q;
                        src_r         = shadow_r_q;
                     end else if (accept) begin
                        // Frame arriving on the boundary skips the shadow
                        bypass     = 1'b1;
                        active_l_d = ch_l;
                        active_r_d = ch_r;
                        src_l      = ch_l;
                        src_r      = ch_r;
                     end else begin
                        underrun_d = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (accept && !bypass) begin
         shadow_l_d    = ch_l;
         shadow_r_d    = ch_r;
         shadow_full_d = 1'b1;
      end

      if (present) begin
         s_l       = pick(src_l, slot_d);
         s_r       = pick(src_r, slot_d);
         mol_d     = {~s_l[8], s_l[7:0]};
         mor_d     = {~s_r[8], s_r[7:0]};
         mol2612_d = {s_l[8], s_l};
         mor2612_d = {s_r[8], s_r};
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         shadow_l_q    <= '0;
         shadow_r_q    <= '0;
         shadow_full_q <= 1'b0;
         active_l_q    <= '0;
         active_r_q    <= '0;
         fm_clk1_q     <= 1'b0;
         fm_sel23_q    <= 1'b0;
         slot_q        <= 3'd0;
         mol_q         <= 9'h100;
         mor_q         <= 9'h100;
         mol2612_q     <= '0;
         mor2612_q     <= '0;
         frame_done_q  <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shadow_l_q    <= shadow_l_d;
         shadow_r_q    <= shadow_r_d;
         shadow_full_q <= shadow_full_d;
         active_l_q    <= active_l_d;
         active_r_q    <= active_r_d;
         fm_clk1_q     <= fm_clk1_d;
         fm_sel23_q    <= fm_sel23_d;
         slot_q        <= slot_d;
         mol_q         <= mol_d;
         mor_q         <= mor_d;
         mol2612_q     <= mol2612_d;
         mor2612_q     <= mor2612_d;
         frame_done_q  <= frame_done_d;
         underrun_q    <= underrun_d;
      end
   end

   assign in_ready   = ~shadow_full_q;
   assign fm_clk1    = fm_clk1_q;
   assign fm_sel23   = fm_sel23_q;
   assign slot       = slot_q;
   assign MOL        = mol_q;
   assign MOR        = mor_q;
   assign MOL_2612   = mol2612_q;
   assign MOR_2612   = mor2612_q;
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_fm_out_seq.sv
// Bench for fm_out_seq: driver pushes accepted frames into a scoreboard queue,
// a negedge monitor replays the frame/slot rules and checks the bus.
module tb_fm_out_seq;

   localparam int unsigned HD = 2;

   typedef struct packed {
      logic [53:0] l;
      logic [53:0] r;
   } frame_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [53:0] ch_l = '0;
   logic [53:0] ch_r = '0;
   logic        fm_clk1, fm_sel23;
   logic [8:0]  MOL, MOR;
   logic [9:0]  MOL_2612, MOR_2612;
   logic [2:0]  slot;
   logic        frame_done, underrun;

   int total = 0;
   int bad   = 0;

   fm_out_seq #(.HALF_DIV(HD)) dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
      .ch_l(ch_l), .ch_r(ch_r), .fm_clk1(fm_clk1), .fm_sel23(fm_sel23),
      .MOL(MOL), .MOR(MOR), .MOL_2612(MOL_2612), .MOR_2612(MOR_2612),
      .slot(slot), .frame_done(frame_done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pending accepted frames and the frame being played
   frame_t q[$];
   frame_t cur;
   logic   mon_en = 1'b0;
   logic   m_idle = 1'b1;
   int     m_slot = 0;
   int     ticks = 0;
   logic   prev_clk1 = 1'b0;

   function automatic logic [8:0] samp(input logic [53:0] b, input int n);
      return b[9*n +: 9];
   endfunction

   function automatic logic [41:0] exp_bus(input frame_t f, input int n);
      logic [8:0] sl, sr;
      sl = samp(f.l, n);
      sr = samp(f.r, n);
      return {(n == 5), 3'(n), ~sl[8], sl[7:0], ~sr[8], sr[7:0],
              sl[8], sl, sr[8], sr};
   endfunction

   // ce pattern: 0 = always, 1 = one in three, 2 = random
   int ce_mode = 0;
   int ce_cyc  = 0;
   initial forever begin
      @(negedge clk);
      #2;
      ce_cyc++;
      case (ce_mode)
         0:       ce = 1'b1;
         1:       ce = (ce_cyc % 3 == 0);
         default: ce = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: runs before the driver within each low phase
   always @(negedge clk) begin
      logic rise, fall, e_fd, e_ur;
      if (mon_en) begin
         if (ce) ticks++;
         rise = fm_clk1 && !prev_clk1;
         fall = !fm_clk1 && prev_clk1;
         e_fd = 1'b0;
         e_ur = 1'b0;
         if (rise) begin
            if (m_idle) begin
               if (q.size() == 0) chk("start_without_frame", 1, 0);
               else begin
                  cur    = q.pop_front();
                  m_idle = 1'b0;
                  m_slot = 0;
               end
            end else begin
               chk("slot_period", 64'(ticks), 64'(2 * HD));
               if (m_slot == 5) begin
                  m_slot = 0;
                  e_fd   = 1'b1;
                  if (q.size() > 0) cur = q.pop_front();
                  else e_ur = 1'b1;
               end else begin
                  m_slot++;
               end
            end
            ticks = 0;
         end else if (fall) begin
            chk("high_width", 64'(ticks), 64'(HD));
         end
         chk("frame_done", 64'(frame_done), 64'(e_fd));
         chk("underrun", 64'(underrun), 64'(e_ur));
         if (m_idle)
            chk("idle_outputs", {fm_clk1, fm_sel23, slot, MOL, MOR, MOL_2612, MOR_2612},
                {1'b0, 1'b0, 3'd0, 9'h100, 9'h100, 10'h000, 10'h000});
         else
            chk("slot_data", {fm_sel23, slot, MOL, MOR, MOL_2612, MOR_2612},
                64'(exp_bus(cur, m_slot)));
         chk("in_ready", 64'(in_ready), 64'(q.size() == 0));
         prev_clk1 = fm_clk1;
      end
   end

   // Offer a frame from a negedge; hold in_valid until accepted
   task automatic send(input frame_t f);
      int n = 0;
      #1;
      in_valid = 1'b1;
      ch_l = f.l;
      ch_r = f.r;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 0, 1);
      end else begin
         q.push_back(f);
         @(negedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_at(input logic [2:0] s, input logic lvl);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(slot == s && fm_clk1 == lvl) && n < 2000);
      if (!(slot == s && fm_clk1 == lvl)) chk("wait_timeout", {s, lvl}, {slot, fm_clk1});
   endtask

   task automatic check_reset_vals(input string nm);
      chk(nm, {in_ready, fm_clk1, fm_sel23, slot, MOL, MOR, MOL_2612, MOR_2612,
               frame_done, underrun},
          {1'b1, 1'b0, 1'b0, 3'd0, 9'h100, 9'h100, 10'h000, 10'h000, 1'b0, 1'b0});
   endtask

   function automatic frame_t rnd_frame();
      frame_t f;
      f.l = 54'({$urandom(), $urandom()});
      f.r = 54'({$urandom(), $urandom()});
      return f;
   endfunction

   initial begin
      frame_t f;
      // reset held with ce running
      repeat (100) @(negedge clk);
      check_reset_vals("reset_values");
      #1 reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (10) @(negedge clk);

      // first frame: -1 and small positive on left, extremes on right
      f.l = '0;
      f.l[8:0]  = 9'h005;
      f.l[17:9] = 9'h1FF;
      f.r = '0;
      f.r[8:0]  = 9'h100;
      f.r[17:9] = 9'h0FF;
      send(f);
      // let it replay with underruns
      repeat (80) @(negedge clk);

      // second frame offered mid-frame goes to shadow
      wait_at(3'd2, 1'b1);
      send(rnd_frame());
      wait_at(3'd0, 1'b1);
      // third frame lands exactly on the boundary cycle
      wait_at(3'd5, 1'b0);
      @(negedge clk);
      send(rnd_frame());
      repeat (60) @(negedge clk);

      // slow ce, then random ce with random traffic
      ce_mode = 1;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 60)) @(negedge clk);
         send(rnd_frame());
      end
      ce_mode = 2;
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 50)) @(negedge clk);
         send(rnd_frame());
      end
      repeat (100) @(negedge clk);

      // reset mid-frame during slot 3 high
      ce_mode = 0;
      wait_at(3'd3, 1'b1);
      #2 reset = 1'b0;
      mon_en = 1'b0;
      #1 check_reset_vals("reset_midframe");
      q.delete();
      m_idle    = 1'b1;
      m_slot    = 0;
      ticks     = 0;
      prev_clk1 = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_vals("reset_held");
      #1 reset = 1'b1;
      mon_en = 1'b1;
      repeat (30) @(negedge clk);
      send(rnd_frame());
      repeat (60) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
